// File: rtl/minority_vote_collector_if.sv
// rtl/minority_vote_collector_if.sv - vote, ballot and verdict handshake bundle
interface minority_vote_collector_if;
    logic       vote_valid;
    logic       vote_bit;
    logic       vote_ready;
    logic [3:0] ballot;
    logic       ballot_valid;
    logic       min_in;
    logic       result;
    logic       result_valid;
    logic       result_ready;

    modport master (
        input  vote_valid, vote_bit, min_in, result_ready,
        output vote_ready, ballot, ballot_valid, result, result_valid
    );

    modport slave (
        output vote_valid, vote_bit, min_in, result_ready,
        input  vote_ready, ballot, ballot_valid, result, result_valid
    );
endinterface

// File: rtl/minority_vote_collector.sv
// rtl/minority_vote_collector.sv - collects four votes into a ballot and returns the minority verdict
module minority_vote_collector #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    minority_vote_collector_if.master bus,
    output logic [CNT_W-1:0]          ballot_count,
    output logic                      err_timeout
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, COLLECT, EVAL, HOLD} stateT;

    stateT            state;
    logic [1:0]       voteIdx;
    logic [TMR_W-1:0] idleTimer;
    logic             voteAccept;
    logic             resultAccept;

    assign voteAccept   = bus.vote_valid & bus.vote_ready;
    assign resultAccept = bus.result_valid & bus.result_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            voteIdx          <= 2'd0;
            idleTimer        <= '0;
            bus.vote_ready   <= 1'b1;
            bus.ballot       <= 4'd0;
            bus.ballot_valid <= 1'b0;
            bus.result       <= 1'b0;
            bus.result_valid <= 1'b0;
            ballot_count     <= '0;
            err_timeout      <= 1'b0;
        end else if (clear) begin
            // Abort wins over any coincident handshake; verdict and tally are kept.
            state            <= IDLE;
            voteIdx          <= 2'd0;
            idleTimer        <= '0;
            bus.vote_ready   <= 1'b1;
            bus.ballot       <= 4'd0;
            bus.ballot_valid <= 1'b0;
            bus.result_valid <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (voteAccept) begin
                        bus.ballot[0] <= bus.vote_bit;
                        voteIdx       <= 2'd1;
                        idleTimer     <= '0;
                        state         <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (voteAccept) begin
                        bus.ballot[voteIdx] <= bus.vote_bit;
                        voteIdx             <= voteIdx + 2'd1;
                        idleTimer           <= '0;
                        if (voteIdx == 2'd3) begin
                            bus.vote_ready   <= 1'b0;
                            bus.ballot_valid <= 1'b1;
                            state            <= EVAL;
                        end
                    end else if (idleTimer == TMR_LAST) begin
                        // The TIMEOUT-th consecutive idle cycle abandons the partial ballot.
                        bus.ballot  <= 4'd0;
                        voteIdx     <= 2'd0;
                        idleTimer   <= '0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idleTimer <= idleTimer + TMR_W'(1);
                    end
                end
                EVAL: begin
                    bus.result       <= bus.min_in;
                    bus.ballot_valid <= 1'b0;
                    bus.result_valid <= 1'b1;
                    state            <= HOLD;
                end
                HOLD: begin
                    if (resultAccept) begin
                        if (ballot_count != CNT_MAX) begin
                            ballot_count <= ballot_count + CNT_W'(1);
                        end
                        bus.ballot       <= 4'd0;
                        bus.result_valid <= 1'b0;
                        bus.vote_ready   <= 1'b1;
                        voteIdx          <= 2'd0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
